// File: rtl/mem_bus_ctrl_if.sv
// Bus-side request/grant/response bundle for mem_bus_ctrl.
// master = snooping bus agent, slave = memory controller.
interface mem_bus_ctrl_if #(
    parameter int AWIDTH = 9,
    parameter int DWIDTH = 32
) ();
    logic              bus_req_rd;
    logic              bus_req_wb;
    logic [AWIDTH-1:0] bus_addr;
    logic [DWIDTH-1:0] bus_wdata;
    logic              bus_gnt;
    logic              bus_rvalid;
    logic [DWIDTH-1:0] bus_rdata;
    logic              wb_full;

    modport master (
        output bus_req_rd, bus_req_wb, bus_addr, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata, wb_full
    );

    modport slave (
        input  bus_req_rd, bus_req_wb, bus_addr, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata, wb_full
    );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Memory-side bus controller: write buffer, read bypass, mem strobes.
// Optional macro WB_FWD_EN: answer reads hitting the write buffer directly.
module mem_bus_ctrl #(
    parameter int AWIDTH   = 9,
    parameter int DWIDTH   = 32,
    parameter int WB_DEPTH = 4,
    parameter int MEM_LAT  = 1
) (
    input  logic              clk,
    input  logic              reset,
    mem_bus_ctrl_if.slave     bus,
    output logic              rd_mem,
    output logic              wr_mem,
    output logic [AWIDTH-1:0] addr_mem,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata,
    input  logic              ready_mem
);
    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = $clog2(MEM_LAT + 1);
    localparam logic [PW:0]   FULL = (PW+1)'(WB_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, RD, RESP, WR} state_t;
    state_t state, state_n;

    logic [AWIDTH-1:0] wb_addr [WB_DEPTH];
    logic [DWIDTH-1:0] wb_data [WB_DEPTH];
    logic [PW-1:0]     head, tail;
    logic [PW:0]       count;
    logic              rd_pend;
    logic [AWIDTH-1:0] rd_addr;
    logic [CW-1:0]     cnt;

    logic              gnt_wb, gnt_rd, pop, last;
    logic              rd_valid, conflict, match, fwd, rd_done;
    logic [AWIDTH-1:0] rd_addr_cur;
    logic [DWIDTH-1:0] match_data;

    assign gnt_wb      = !reset && bus.bus_req_wb && !bus.wb_full;
    assign gnt_rd      = !reset && bus.bus_req_rd && !bus.bus_req_wb
                         && !rd_pend;
    assign bus.bus_gnt = gnt_wb | gnt_rd;
    assign bus.wb_full = (count == FULL);
    assign last        = (cnt == LAST);
    assign rd_done     = (state == RD) && last;
    // A read granted this cycle can start memory access at the same edge.
    assign rd_addr_cur = rd_pend ? rd_addr : bus.bus_addr;

    // Youngest matching entry wins: later iterations overwrite earlier.
    always_comb begin
        match      = 1'b0;
        match_data = '0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            if ((PW+1)'(k) < count &&
                wb_addr[head + PW'(k)] == rd_addr_cur) begin
                match      = 1'b1;
                match_data = wb_data[head + PW'(k)];
            end
        end
    end

`ifdef WB_FWD_EN
    assign fwd      = gnt_rd && match;
    assign conflict = 1'b0;
`else
    assign fwd      = 1'b0;
    assign conflict = match;
`endif

    assign rd_valid = rd_pend || (gnt_rd && !fwd);

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                if (ready_mem) begin
                    if (rd_valid && !conflict)
                        state_n = RD;
                    else if (count != '0)
                        state_n = WR;
                end
            end
            RD:   if (last) state_n = RESP;
            RESP: state_n = IDLE;
            WR: begin
                if (last) begin
                    state_n = IDLE;
                    pop     = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (gnt_wb) begin
            wb_addr[tail] <= bus.bus_addr;
            wb_data[tail] <= bus.bus_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            rd_pend        <= 1'b0;
            rd_addr        <= '0;
            cnt            <= '0;
            rd_mem         <= 1'b0;
            wr_mem         <= 1'b0;
            addr_mem       <= '0;
            mem_wdata      <= '0;
            bus.bus_rvalid <= 1'b0;
            bus.bus_rdata  <= '0;
        end else begin
            state  <= state_n;
            cnt    <= (state_n == state) ? cnt + 1'b1 : '0;
            rd_mem <= (state_n == RD);
            wr_mem <= (state_n == WR);
            if (state == IDLE && state_n == RD)
                addr_mem <= rd_addr_cur;
            if (state == IDLE && state_n == WR) begin
                addr_mem  <= wb_addr[head];
                mem_wdata <= wb_data[head];
            end
            if (gnt_wb)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            if (gnt_wb && !pop)
                count <= count + 1'b1;
            else if (!gnt_wb && pop)
                count <= count - 1'b1;
            if (gnt_rd && !fwd) begin
                rd_pend <= 1'b1;
                rd_addr <= bus.bus_addr;
            end else if (rd_done) begin
                rd_pend <= 1'b0;
            end
            bus.bus_rvalid <= rd_done || fwd;
            if (rd_done)
                bus.bus_rdata <= mem_rdata;
            else if (fwd)
                bus.bus_rdata <= match_data;
        end
    end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed cases plus random traffic.
// Reference: every read returns the latest write-back granted to its address.
module tb_mem_bus_ctrl;
    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rd_mem, wr_mem;
    logic [AW-1:0] addr_mem;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          ready_mem = 1'b1;

    mem_bus_ctrl_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

    mem_bus_ctrl #(
        .AWIDTH(AW), .DWIDTH(DW), .WB_DEPTH(4), .MEM_LAT(1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .rd_mem    (rd_mem),
        .wr_mem    (wr_mem),
        .addr_mem  (addr_mem),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .ready_mem (ready_mem)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [DW-1:0] shadow [512];
    logic [DW-1:0] mem    [512];
    bit            mem_w  [512];
    logic [AW:0]   log_q  [$];
    int            rd_cnt = 0;
    int            wr_cnt = 0;
    bit            rd_prev = 0, wr_prev = 0;
    bit            rand_ready = 0;
    bit            ready_ctl = 1;

    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        return mem_w[a] ? mem[a] : 32'h0000_00A0 + 32'(a);
    endfunction

    // Memory model: samples strobes on the falling edge.
    always @(negedge clk) begin
        ready_mem = rand_ready ? ($urandom_range(0, 3) != 0) : ready_ctl;
        if (wr_mem) begin
            mem[addr_mem]   = mem_wdata;
            mem_w[addr_mem] = 1'b1;
            if (!wr_prev) begin
                wr_cnt++;
                log_q.push_back({1'b1, addr_mem});
            end
        end
        if (rd_mem) begin
            mem_rdata = mem_val(addr_mem);
            if (!rd_prev) begin
                rd_cnt++;
                log_q.push_back({1'b0, addr_mem});
            end
        end
        wr_prev = wr_mem;
        rd_prev = rd_mem;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        assert (got === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit upd);
        bit g = 0;
        bus.bus_req_wb = 1'b1;
        bus.bus_addr   = a;
        bus.bus_wdata  = d;
        for (int i = 0; i < 300 && !g; i++) begin
            #1;
            g = bus.bus_gnt;
            tick();
        end
        bus.bus_req_wb = 1'b0;
        check("wb_gnt", 32'(g), 32'd1);
        if (g && upd) shadow[a] = d;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        bit g = 0;
        bit v = 0;
        bus.bus_req_rd = 1'b1;
        bus.bus_addr   = a;
        for (int i = 0; i < 300 && !g; i++) begin
            #1;
            g = bus.bus_gnt;
            tick();
        end
        bus.bus_req_rd = 1'b0;
        check("rd_gnt", 32'(g), 32'd1);
        for (int i = 0; i < 300 && !v; i++) begin
            if (bus.bus_rvalid) v = 1;
            else tick();
        end
        check("rd_rvalid", 32'(v), 32'd1);
        check("rd_data", bus.bus_rdata, shadow[a]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base, rd0, wr0, wi, ri;
        bit seen, any_v, any_w;
        for (int i = 0; i < 512; i++)
            shadow[i] = 32'h0000_00A0 + 32'(i);
        bus.bus_req_rd = 1'b1;
        bus.bus_req_wb = 1'b1;
        bus.bus_addr   = 9'h001;
        bus.bus_wdata  = 32'h1;

        // Reset state, with both requests asserted.
        tick();
        tick();
        check("rst_rd_mem", 32'(rd_mem), 0);
        check("rst_wr_mem", 32'(wr_mem), 0);
        check("rst_addr_mem", 32'(addr_mem), 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rvalid", 32'(bus.bus_rvalid), 0);
        check("rst_rdata", bus.bus_rdata, 0);
        check("rst_wb_full", 32'(bus.wb_full), 0);
        check("rst_gnt", 32'(bus.bus_gnt), 0);
        bus.bus_req_rd = 1'b0;
        bus.bus_req_wb = 1'b0;
        reset = 1'b0;
        tick();
        tick();

        // Single read with exact latency.
        bus.bus_req_rd = 1'b1;
        bus.bus_addr   = 9'h005;
        #1;
        check("rd1_gnt", 32'(bus.bus_gnt), 1);
        tick();
        bus.bus_req_rd = 1'b0;
        check("rd1_rd_mem_c1", 32'(rd_mem), 1);
        check("rd1_addr_c1", 32'(addr_mem), 32'h005);
        check("rd1_rvalid_c1", 32'(bus.bus_rvalid), 0);
        tick();
        check("rd1_rvalid_c2", 32'(bus.bus_rvalid), 1);
        check("rd1_rdata", bus.bus_rdata, 32'h0000_00A5);
        tick();
        check("rd1_rvalid_c3", 32'(bus.bus_rvalid), 0);
        repeat (4) tick();

        // Fill the buffer with memory stalled.
        ready_ctl = 0;
        base = log_q.size();
        wr0  = wr_cnt;
        for (int i = 0; i < 4; i++)
            wb(9'h010 + 9'(i), 32'h1111_0000 + 32'(i), 1);
        check("fill_full", 32'(bus.wb_full), 1);
        bus.bus_req_wb = 1'b1;
        bus.bus_addr   = 9'h014;
        bus.bus_wdata  = 32'h1111_0004;
        #1;
        check("fill_5th_held", 32'(bus.bus_gnt), 0);
        ready_ctl = 1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            #1;
            seen = bus.bus_gnt;
        end
        check("fill_5th_gnt", 32'(seen), 1);
        check("fill_pop_first", 32'(wr_cnt - wr0), 1);
        tick();
        bus.bus_req_wb = 1'b0;
        shadow[9'h014] = 32'h1111_0004;
        repeat (30) tick();
        for (int i = 0; i < 5; i++) begin
            check("fill_order", 32'(log_q[base + i]), 32'({1'b1, 9'h010 + 9'(i)}));
            check("fill_mem", mem_val(9'h010 + 9'(i)), 32'h1111_0000 + 32'(i));
        end

        // Write-back then immediate read of the same address.
        base = log_q.size();
        wb(9'h020, 32'hDEAD_BEEF, 1);
        bus.bus_req_rd = 1'b1;
        bus.bus_addr   = 9'h020;
        #1;
        check("raw_gnt", 32'(bus.bus_gnt), 1);
        rd0 = rd_cnt;
        tick();
        bus.bus_req_rd = 1'b0;
`ifdef WB_FWD_EN
        check("raw_fwd_rvalid", 32'(bus.bus_rvalid), 1);
        check("raw_fwd_rdata", bus.bus_rdata, 32'hDEAD_BEEF);
        repeat (6) tick();
        check("raw_fwd_no_rd", 32'(rd_cnt - rd0), 0);
`else
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (bus.bus_rvalid) seen = 1;
            else tick();
        end
        check("raw_rvalid", 32'(seen), 1);
        check("raw_rdata", bus.bus_rdata, 32'hDEAD_BEEF);
        wi = -1;
        ri = -1;
        for (int i = base; i < log_q.size(); i++) begin
            if (wi < 0 && log_q[i] == {1'b1, 9'h020}) wi = i;
            if (ri < 0 && log_q[i] == {1'b0, 9'h020}) ri = i;
        end
        check("raw_wr_before_rd", 32'(wi >= 0 && ri > wi), 1);
`endif
        repeat (10) tick();

        // Two writes to one address; the younger must be returned.
        wb(9'h030, 32'h1, 1);
        wb(9'h030, 32'h2, 1);
        rd(9'h030);
        check("youngest", bus.bus_rdata, 32'h2);
        repeat (10) tick();

        // Simultaneous requests: write-back first, read the next cycle.
        bus.bus_req_wb = 1'b1;
        bus.bus_req_rd = 1'b1;
        bus.bus_addr   = 9'h040;
        bus.bus_wdata  = 32'h4040_4040;
        #1;
        check("both_gnt_wb", 32'(bus.bus_gnt), 1);
        tick();
        bus.bus_req_wb = 1'b0;
        shadow[9'h040] = 32'h4040_4040;
        #1;
        check("both_gnt_rd", 32'(bus.bus_gnt), 1);
        tick();
        bus.bus_req_rd = 1'b0;
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (bus.bus_rvalid) seen = 1;
            else tick();
        end
        check("both_rvalid", 32'(seen), 1);
        check("both_rdata", bus.bus_rdata, 32'h4040_4040);
        repeat (10) tick();

        // Reset during the read strobe with two buffered writes.
        ready_ctl = 0;
        wb(9'h050, 32'h5050_0000, 0);
        wb(9'h051, 32'h5050_0001, 0);
        bus.bus_req_rd = 1'b1;
        bus.bus_addr   = 9'h060;
        #1;
        check("rst_rd_gnt", 32'(bus.bus_gnt), 1);
        tick();
        bus.bus_req_rd = 1'b0;
        ready_ctl = 1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = rd_mem;
        end
        check("rst_rd_started", 32'(seen), 1);
        wr0 = wr_cnt;
        reset = 1'b1;
        tick();
        check("rst_mid_rd_mem", 32'(rd_mem), 0);
        any_v = bus.bus_rvalid;
        tick();
        reset = 1'b0;
        any_w = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            any_v |= bus.bus_rvalid;
            any_w |= wr_mem;
        end
        check("rst_mid_no_rvalid", 32'(any_v), 0);
        check("rst_mid_no_wr", 32'(any_w), 0);
        check("rst_mid_wr_cnt", 32'(wr_cnt - wr0), 0);
        check("rst_mid_wb_full", 32'(bus.wb_full), 0);

        // Random traffic against the reference model.
        rand_ready = 1;
        for (int n = 0; n < 150; n++) begin
            logic [AW-1:0] a;
            a = 9'h100 + 9'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1)
                wb(a, $urandom, 1);
            else
                rd(a);
        end
        rand_ready = 0;
        repeat (60) tick();
        for (int i = 0; i < 8; i++)
            check("rand_mem", mem_val(9'h100 + 9'(i)), shadow[9'h100 + i]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
